// File: rtl/dcache_pkg.sv
// Shared types, field widths and address/byte helpers for the direct-mapped data cache.
package dcache_pkg;

   localparam int OFF_W      = 2;
   localparam int DEF_LINES  = 8;
   localparam int DEF_ADDR_W = 8;
   localparam int IDX_W      = $clog2(DEF_LINES);
   localparam int TAG_W      = DEF_ADDR_W - IDX_W - OFF_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

   // Address fields are returned right-justified; callers cast to their field width.
   function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int idx_w);
      return (addr >> OFF_W) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w, input int tag_w);
      return (addr >> (OFF_W + idx_w)) & ((32'd1 << tag_w) - 32'd1);
   endfunction

   function automatic logic [OFF_W-1:0] addr_off(input logic [31:0] addr);
      return OFF_W'(addr);
   endfunction

   function automatic logic [7:0] get_byte(input logic [31:0] blk, input logic [OFF_W-1:0] off);
      return blk[8*off +: 8];
   endfunction

   function automatic logic [31:0] put_byte(input logic [31:0] blk, input logic [OFF_W-1:0] off,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = blk;
      r[8*off +: 8] = b;
      return r;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: LINES x 32-bit data, tags, valid and dirty bits; async read, sync byte/block write.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int LINES = 8,
   parameter int TW    = 3,
   parameter int IW    = $clog2(LINES)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [IW-1:0]    idx,
   input  logic             byte_we,
   input  logic [OFF_W-1:0] byte_off,
   input  logic [7:0]       byte_data,
   input  logic             blk_we,
   input  logic [31:0]      blk_data,
   input  logic [TW-1:0]    blk_tag,
   output logic [31:0]      rd_data,
   output logic [TW-1:0]    rd_tag,
   output logic             rd_valid,
   output logic             rd_dirty
);

   logic [31:0]      data_q [LINES];
   logic [TW-1:0]    tag_q  [LINES];
   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (blk_we) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (byte_we) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // NOTE: data and tags carry no reset; they are meaningless until valid is set, so they map to plain RAM.
   always_ff @(posedge CLK) begin
      if (blk_we) begin
         data_q[idx] <= blk_data;
         tag_q[idx]  <= blk_tag;
      end else if (byte_we) begin
         data_q[idx] <= put_byte(data_q[idx], byte_off, byte_data);
      end
   end

   assign rd_data  = data_q[idx];
   assign rd_tag   = tag_q[idx];
   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller with refill/write-back FSM.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT / WB_COUNT outputs.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int LINES       = 8,
   parameter int BLOCK_BYTES = 4,
   parameter int ADDR_W      = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              READ,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] ADDRESS,
   input  logic [7:0]        WRITEDATA,
   output logic [7:0]        READDATA,
   output logic              BUSYWAIT,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [ADDR_W-3:0] MEM_ADDRESS,
   output logic [31:0]       MEM_WRITEDATA,
   input  logic [31:0]       MEM_READDATA,
   input  logic              MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]       HIT_COUNT,
   output logic [15:0]       MISS_COUNT,
   output logic [15:0]       WB_COUNT
`endif
);

   localparam int IW = $clog2(LINES);
   localparam int TW = ADDR_W - IW - OFF_W;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx;
   logic [TW-1:0]    tag;
   logic [OFF_W-1:0] off;
   logic [31:0]      line_data, fill_q;
   logic [TW-1:0]    line_tag;
   logic             line_valid, line_dirty;
   logic             req, hit, miss, byte_we, blk_we;

   assign idx  = IW'(addr_idx(32'(ADDRESS), IW));
   assign tag  = TW'(addr_tag(32'(ADDRESS), IW, TW));
   assign off  = addr_off(32'(ADDRESS));
   assign req  = READ | WRITE;
   assign hit  = line_valid && (line_tag == tag);
   assign miss = (state_q == IDLE) && req && !hit;

   dcache_array #(.LINES(LINES), .TW(TW), .IW(IW)) u_array (
      .CLK      (CLK),
      .RESET    (RESET),
      .idx      (idx),
      .byte_we  (byte_we),
      .byte_off (off),
      .byte_data(WRITEDATA),
      .blk_we   (blk_we),
      .blk_data (fill_q),
      .blk_tag  (tag),
      .rd_data  (line_data),
      .rd_tag   (line_tag),
      .rd_valid (line_valid),
      .rd_dirty (line_dirty)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge CLK) begin
      if (state_q == FETCH && !MEM_BUSYWAIT) fill_q <= MEM_READDATA;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (miss) state_d = line_dirty ? WRITEBACK : FETCH;
         WRITEBACK: if (!MEM_BUSYWAIT) state_d = FETCH;
         FETCH:     if (!MEM_BUSYWAIT) state_d = UPDATE;
         UPDATE:    state_d = IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = {tag, idx};
      MEM_WRITEDATA = line_data;
      BUSYWAIT      = 1'b1;
      READDATA      = 8'h00;
      byte_we       = 1'b0;
      blk_we        = 1'b0;
      unique case (state_q)
         IDLE: begin
            BUSYWAIT = req && !hit;
            if (READ && hit) READDATA = get_byte(line_data, off);
            byte_we  = WRITE && hit;
         end
         WRITEBACK: begin
            MEM_WRITE   = 1'b1;
            MEM_ADDRESS = {line_tag, idx};
         end
         FETCH:  MEM_READ = 1'b1;
         UPDATE: blk_we   = 1'b1;
      endcase
      // The stall drops together with the strobes while reset is held.
      if (!RESET) BUSYWAIT = 1'b0;
   end

`ifdef DCACHE_STATS_EN
   logic missed_q;
   logic hit_done;

   assign hit_done = (state_q == IDLE) && req && hit;

   // missed_q marks a request that has already missed, so its final hit is not counted.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         missed_q   <= 1'b0;
         HIT_COUNT  <= '0;
         MISS_COUNT <= '0;
         WB_COUNT   <= '0;
      end else begin
         if (miss)          missed_q <= 1'b1;
         else if (hit_done) missed_q <= 1'b0;
         if (hit_done && !missed_q) HIT_COUNT  <= sat_inc(HIT_COUNT);
         if (miss)                  MISS_COUNT <= sat_inc(MISS_COUNT);
         if (miss && line_dirty)    WB_COUNT   <= sat_inc(WB_COUNT);
      end
   end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a 5-cycle block memory model.
`timescale 1ns/1ps
module tb_dcache_controller;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        READ = 1'b0;
   logic        WRITE = 1'b0;
   logic [7:0]  ADDRESS = 8'h00;
   logic [7:0]  WRITEDATA = 8'h00;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
   logic [15:0] HIT_COUNT, MISS_COUNT, WB_COUNT;
`endif

   int total = 0;
   int bad = 0;

   dcache_controller dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .READ         (READ),
      .WRITE        (WRITE),
      .ADDRESS      (ADDRESS),
      .WRITEDATA    (WRITEDATA),
      .READDATA     (READDATA),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_WRITE    (MEM_WRITE),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
      ,
      .HIT_COUNT    (HIT_COUNT),
      .MISS_COUNT   (MISS_COUNT),
      .WB_COUNT     (WB_COUNT)
`endif
   );

   always #5 CLK = ~CLK;

   // Memory model: byte i holds i ^ 8'h27; each strobe completes on its 5th cycle.
   logic [7:0] mem [256];
   int         mem_cnt;
   logic       mem_load = 1'b1;

   assign MEM_READDATA = {mem[{MEM_ADDRESS, 2'd3}], mem[{MEM_ADDRESS, 2'd2}],
                          mem[{MEM_ADDRESS, 2'd1}], mem[{MEM_ADDRESS, 2'd0}]};
   assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < 4);

   always @(posedge CLK) begin
      if (mem_load) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i ^ 'h27);
         mem_cnt <= 0;
      end else if (MEM_READ | MEM_WRITE) begin
         if (mem_cnt == 4) begin
            mem_cnt <= 0;
            if (MEM_WRITE)
               for (int b = 0; b < 4; b++) mem[{MEM_ADDRESS, 2'(b)}] <= MEM_WRITEDATA[8*b +: 8];
         end else begin
            mem_cnt <= mem_cnt + 1;
         end
      end else begin
         mem_cnt <= 0;
      end
   end

   // Per-access observations.
   int          acc_cycles;
   logic [7:0]  acc_rdata;
   logic        acc_busy0, log_rd, log_wr, wr_first, both_hi;
   logic [5:0]  log_rd_addr, log_wr_addr;
   logic [31:0] log_wr_data;

   task automatic sample_strobes();
      if (MEM_READ && MEM_WRITE) both_hi = 1'b1;
      if (MEM_WRITE && !log_wr) begin
         log_wr      = 1'b1;
         log_wr_addr = MEM_ADDRESS;
         log_wr_data = MEM_WRITEDATA;
      end
      if (MEM_READ && !log_rd) begin
         log_rd      = 1'b1;
         log_rd_addr = MEM_ADDRESS;
         wr_first    = log_wr;
      end
   endtask

   task automatic do_access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
      log_rd = 1'b0; log_wr = 1'b0; wr_first = 1'b0; both_hi = 1'b0;
      log_rd_addr = '0; log_wr_addr = '0; log_wr_data = '0;
      @(negedge CLK);
      READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
      #1;
      acc_busy0  = BUSYWAIT;
      acc_cycles = 1;
      sample_strobes();
      while (BUSYWAIT && acc_cycles < 200) begin
         @(negedge CLK); #1;
         acc_cycles++;
         sample_strobes();
      end
      acc_rdata = READDATA;
      @(negedge CLK);
      READ = 1'b0; WRITE = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge CLK); @(negedge CLK);
      READ = 1'b1; ADDRESS = 8'h05; #1;
      total++; if (BUSYWAIT !== 1'b0) begin bad++; $display("FAIL rst_busywait: got %b want 0", BUSYWAIT); end
      total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL rst_mem_read: got %b want 0", MEM_READ); end
      total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL rst_mem_write: got %b want 0", MEM_WRITE); end
      total++; if (READDATA !== 8'h00) begin bad++; $display("FAIL rst_readdata: got %h want 00", READDATA); end
      READ = 1'b0;
      @(negedge CLK);
      mem_load = 1'b0; RESET = 1'b1;
   endtask

   task automatic test_read_miss();
      do_access(1'b1, 1'b0, 8'h05, 8'h00);
      total++; if (acc_busy0 !== 1'b1) begin bad++; $display("FAIL miss_busy_same_cycle: got %b want 1", acc_busy0); end
      total++; if (!(log_rd && log_rd_addr == 6'h01)) begin bad++; $display("FAIL miss_mem_read: got seen=%b addr=%h want seen=1 addr=01", log_rd, log_rd_addr); end
      total++; if (log_wr !== 1'b0) begin bad++; $display("FAIL miss_no_writeback: got %b want 0", log_wr); end
      total++; if (acc_cycles != 8) begin bad++; $display("FAIL miss_cycles: got %0d want 8", acc_cycles); end
      total++; if (acc_rdata !== 8'h22) begin bad++; $display("FAIL miss_readdata: got %h want 22", acc_rdata); end
   endtask

   task automatic test_read_hit();
      do_access(1'b1, 1'b0, 8'h06, 8'h00);
      total++; if (acc_busy0 !== 1'b0 || acc_cycles != 1) begin bad++; $display("FAIL hit_stall: got busy=%b cycles=%0d want busy=0 cycles=1", acc_busy0, acc_cycles); end
      total++; if (acc_rdata !== 8'h21) begin bad++; $display("FAIL hit_readdata: got %h want 21", acc_rdata); end
      total++; if (log_rd || log_wr) begin bad++; $display("FAIL hit_no_strobe: got rd=%b wr=%b want 0 0", log_rd, log_wr); end
   endtask

   task automatic test_write_hit();
      do_access(1'b0, 1'b1, 8'h05, 8'hAB);
      total++; if (acc_busy0 !== 1'b0 || acc_cycles != 1) begin bad++; $display("FAIL wr_hit_stall: got busy=%b cycles=%0d want busy=0 cycles=1", acc_busy0, acc_cycles); end
      total++; if (log_rd || log_wr) begin bad++; $display("FAIL wr_hit_no_strobe: got rd=%b wr=%b want 0 0", log_rd, log_wr); end
      do_access(1'b1, 1'b0, 8'h05, 8'h00);
      total++; if (acc_rdata !== 8'hAB || acc_cycles != 1) begin bad++; $display("FAIL wr_readback: got %h cycles=%0d want ab cycles=1", acc_rdata, acc_cycles); end
      total++; if (dut.u_array.dirty_q[1] !== 1'b1) begin bad++; $display("FAIL wr_dirty: got %b want 1", dut.u_array.dirty_q[1]); end
   endtask

   task automatic test_writeback();
      do_access(1'b1, 1'b0, 8'h25, 8'h00);
      total++; if (!(log_wr && log_wr_addr == 6'h01)) begin bad++; $display("FAIL wb_mem_write: got seen=%b addr=%h want seen=1 addr=01", log_wr, log_wr_addr); end
      total++; if (log_wr_data[15:8] !== 8'hAB) begin bad++; $display("FAIL wb_data: got %h want ab", log_wr_data[15:8]); end
      total++; if (!(log_rd && wr_first && log_rd_addr == 6'h09)) begin bad++; $display("FAIL wb_then_fetch: got rd=%b after_wr=%b addr=%h want 1 1 09", log_rd, wr_first, log_rd_addr); end
      total++; if (both_hi) begin bad++; $display("FAIL wb_strobes_exclusive: got both high want never"); end
      total++; if (acc_cycles != 13) begin bad++; $display("FAIL wb_cycles: got %0d want 13", acc_cycles); end
      total++; if (acc_rdata !== 8'h02) begin bad++; $display("FAIL wb_readdata: got %h want 02", acc_rdata); end
      total++; if (mem[5] !== 8'hAB) begin bad++; $display("FAIL wb_mem_byte5: got %h want ab", mem[5]); end
   endtask

   task automatic test_reset_midfetch();
      int guard = 0;
      @(negedge CLK);
      READ = 1'b1; ADDRESS = 8'h05; #1;
      while (!MEM_READ && guard < 20) begin
         @(negedge CLK); #1;
         guard++;
      end
      total++; if (MEM_READ !== 1'b1) begin bad++; $display("FAIL midfetch_reached: got %b want 1", MEM_READ); end
`ifdef DCACHE_STATS_EN
      total++; if (HIT_COUNT !== 16'd3) begin bad++; $display("FAIL stats_hit: got %0d want 3", HIT_COUNT); end
      total++; if (MISS_COUNT !== 16'd3) begin bad++; $display("FAIL stats_miss: got %0d want 3", MISS_COUNT); end
      total++; if (WB_COUNT !== 16'd1) begin bad++; $display("FAIL stats_wb: got %0d want 1", WB_COUNT); end
`endif
      @(posedge CLK); #2;
      RESET = 1'b0; #1;
      total++; if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin bad++; $display("FAIL midfetch_abort: got mem_read=%b busy=%b want 0 0", MEM_READ, BUSYWAIT); end
`ifdef DCACHE_STATS_EN
      total++; if (HIT_COUNT !== 16'd0 || MISS_COUNT !== 16'd0 || WB_COUNT !== 16'd0) begin bad++; $display("FAIL stats_clear: got %0d %0d %0d want 0 0 0", HIT_COUNT, MISS_COUNT, WB_COUNT); end
`endif
      @(negedge CLK);
      RESET = 1'b1; READ = 1'b0;
      do_access(1'b1, 1'b0, 8'h05, 8'h00);
      total++; if (acc_busy0 !== 1'b1 || !log_rd || log_rd_addr != 6'h01) begin bad++; $display("FAIL post_reset_miss: got busy=%b rd=%b addr=%h want 1 1 01", acc_busy0, log_rd, log_rd_addr); end
      total++; if (acc_rdata !== 8'hAB || acc_cycles != 8) begin bad++; $display("FAIL post_reset_data: got %h cycles=%0d want ab cycles=8", acc_rdata, acc_cycles); end
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_hit();
      test_writeback();
      test_reset_midfetch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller. It sits between the CPU load/store port and the 256-byte word-block data memory.
- It owns the tag/valid/dirty arrays and the data array. A sequencing FSM performs write-back and refill against the slow memory.
- The CPU is stalled through BUSYWAIT for every miss.

Parameters:
- LINES, 8, number of cache lines (power of 2); index width = log2(LINES).
- BLOCK_BYTES, 4, bytes per block; fixed at 4 because the memory port is 32 bits. Offset width = 2.
- ADDR_W, 8, CPU byte-address width; tag width = ADDR_W - index - offset (3 at defaults).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request; held high until BUSYWAIT is low.
- WRITE  in  1  CPU store request; held high until BUSYWAIT is low. Never high together with READ.
- ADDRESS  in  ADDR_W  CPU byte address.
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  block read strobe.
- MEM_WRITE  out  1  block write strobe.
- MEM_ADDRESS  out  ADDR_W-2  block address {tag,index}.
- MEM_WRITEDATA  out  32  block to write; byte 0 is in [7:0].
- MEM_READDATA  in  32  returned block.
- MEM_BUSYWAIT  in  1  memory busy; low marks completion of the current strobe.

Behaviour:
- Reset (RESET low, asynchronous):
  - state=IDLE; all valid and dirty bits cleared.
  - MEM_READ=0, MEM_WRITE=0, BUSYWAIT=0, READDATA=0.
  - Tags and data need no reset.
  - Reset asserted mid-refill or mid-write-back aborts the transaction immediately; the strobes drop in the same time step.
- Hit: valid[index] && tag[index]==ADDRESS tag field. Evaluated combinationally in IDLE.
- Read hit:
  - READDATA = selected byte, combinationally in the same cycle.
  - BUSYWAIT stays 0; zero-wait.
- Write hit:
  - BUSYWAIT stays 0.
  - At the next posedge the byte is written and dirty=1.
- BUSYWAIT = (READ|WRITE) && !hit in IDLE, OR state != IDLE. It is combinational so a miss stalls the CPU within the request cycle.
- FSM states:
  - IDLE:
    - Miss and dirty[index]: go to WRITEBACK.
    - Miss and clean: go to FETCH.
    - Otherwise stay in IDLE.
  - WRITEBACK:
    - MEM_WRITE=1, MEM_ADDRESS={old tag,index}, MEM_WRITEDATA=line data.
    - At a posedge with MEM_BUSYWAIT=0: go to FETCH. Strobe deasserts on the transition.
  - FETCH:
    - MEM_READ=1, MEM_ADDRESS={ADDRESS tag,index}.
    - At a posedge with MEM_BUSYWAIT=0: capture MEM_READDATA, go to UPDATE.
  - UPDATE:
    - One cycle.
    - Line data = captured block, tag = new tag, valid=1, dirty=0.
    - Go to IDLE, where the request now hits and completes normally (store sets dirty).
- Miss latency: clean = 1 (IDLE) + memory latency + 1 (UPDATE) + hit cycle; dirty adds the write-back duration.
- Strobes are mutually exclusive and are never both high.
- READ/WRITE dropping while not in IDLE: the current transaction still completes. Requests are not cancelled.
- Index wrap: line LINES-1 neighbours line 0 with no special handling. Conflict eviction is pure direct-mapped.

Optional Feature:
- DCACHE_STATS_EN defined:
  - Adds outputs HIT_COUNT[15:0], MISS_COUNT[15:0] and WB_COUNT[15:0].
  - HIT increments once per completed access that hit on first presentation.
  - MISS increments on each IDLE→FETCH/WRITEBACK transition.
  - WB increments on each WRITEBACK entry.
  - Counters saturate at 16'hFFFF and are cleared by RESET.
- Undefined: none of these ports or registers exist.

Decomposition:
- Shared package dcache_pkg:
  - State enum (IDLE, WRITEBACK, FETCH, UPDATE).
  - Field-width localparams (TAG_W, IDX_W, OFF_W).
  - Address-split helper functions.
- One natural sub-module: dcache_array. It holds the LINES×32 data plus tag/valid/dirty storage, with combinational read and synchronous byte/block write. The FSM, hit logic and muxing stay in dcache_controller.

Test Plan:
- Bench memory model has a 5-cycle latency.
- After reset, read 0x05 (memory byte 5 = 0x22):
  - BUSYWAIT high the same cycle.
  - MEM_READ with MEM_ADDRESS=0x01.
  - After UPDATE, READDATA=0x22 and BUSYWAIT low.
  - Total 8 stall cycles.
- Then read 0x06 → hit. READDATA = memory byte 6 with zero stall; no MEM strobe.
- Write 0xAB to 0x05 → hit with no stall. The next read of 0x05 returns 0xAB and dirty[1]=1.
- Read 0x25 (same index 1, tag 1):
  - MEM_WRITE first, with MEM_ADDRESS=0x01 and MEM_WRITEDATA[15:8]=0xAB.
  - Then MEM_READ with MEM_ADDRESS=0x09.
  - The memory model shows byte 5 = 0xAB afterwards.
- Assert RESET low during FETCH:
  - MEM_READ and BUSYWAIT drop immediately.
  - Re-reading 0x05 misses again (valid was cleared).
- With DCACHE_STATS_EN defined, run the full sequence above. Final HIT_COUNT=3, MISS_COUNT=3, WB_COUNT=1.
